pipe_subtractor64: RTL
======================

Name: pipe_subtractor64

Overview:
- Pipelined 64-bit unsigned/two's-complement subtractor: DIFF = A - B, with borrow-out and signed-overflow flags.
- Companion of sparse_adder64 for the datapath: the inverse operation, registered and flow-controlled.
- Splits the operand into STAGES equal slices. Each stage resolves one slice and passes the borrow forward.
- Valid/ready on both sides, with per-stage bubble collapsing.

Parameters:
- WIDTH, 64, operand and result width; must be divisible by STAGES.
- STAGES, 4, pipeline depth = number of slices, each WIDTH/STAGES bits; legal range 1..WIDTH.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  A/B valid this cycle.
- in_ready  output  1  block accepts A/B this cycle.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- out_valid  output  1  DIFF/BO/OV valid.
- out_ready  input  1  downstream accepts result.
- DIFF  output  WIDTH  A - B mod 2^WIDTH.
- BO  output  1  borrow out; 1 iff A < B unsigned.
- OV  output  1  signed overflow = (A[MSB]^B[MSB]) & (A[MSB]^DIFF[MSB]).

Behaviour:
- Reset (rst_n low, asynchronous assert): all stage valid bits clear, so out_valid=0.
  - DIFF, BO, OV reset to 0.
  - in_ready reflects empty stage 0 (1) once reset deasserts.
  - Deassert is sampled synchronously on clk.
- Transfer occurs on a rising edge with valid&ready high on that side. A/B are captured only on input transfer.
- Stage k (0..STAGES-1):
  - Holds the fully-resolved low (k+1) slices of DIFF, the borrow out of slice k, and the unprocessed upper slices of A and B.
  - Slice k is computed as A_k - B_k - borrow_in, with borrow_in=0 for slice 0.
  - Equivalently: A_k + ~B_k + carry, where carry_in for slice 0 = 1 and BO = ~final carry.
- Stage advance:
  - adv[last] = v[last] & out_ready, or !v[last].
  - adv[k] = !v[k+1] or adv[k+1].
  - Stage k loads from k-1 when adv[k]; its valid becomes v[k-1] when it advances.
  - Registers hold when not advancing.
- in_ready = !v[0] | adv[0]. This is combinational from out_ready through the chain; no combinational path from in_valid to in_ready.
- Latency: 4 cycles (STAGES) from input transfer to out_valid, with no stall. Throughput: one result per cycle with out_ready held high.
- Outputs are driven directly from the last stage register. DIFF/BO/OV stay stable while out_valid=1 and out_ready=0.
- Ordering: results emerge in acceptance order; no drop, no duplicate.
- Bubbles: an empty stage is filled even while downstream is stalled. With out_ready=0, up to STAGES operations are accepted before in_ready drops.
- Simultaneous accept and emit on a full pipeline: permitted in the same cycle (in_ready=1 when out_ready=1).
- Wrap-around: DIFF is modulo 2^WIDTH with no saturation. A=0, B=1 gives DIFF=all ones, BO=1.
- Reset mid-operation: all in-flight results are discarded and out_valid falls asynchronously. Nothing is emitted after reset releases until new input is accepted.
- in_valid with X on A/B while in_ready=0 must not corrupt state.

Test Plan:
- Directed single op, out_ready=1: A=0x0000_0000_0000_0005, B=3. Out_valid exactly 4 cycles later with DIFF=2, BO=0, OV=0.
- Borrow ripple across all slices: A=0, B=1 → DIFF=0xFFFF_FFFF_FFFF_FFFF, BO=1, OV=0.
- Slice-boundary borrow: A=0x0000_0000_0001_0000, B=1 → DIFF=0x0000_0000_0000_FFFF, BO=0.
- Signed overflow: A=0x8000_0000_0000_0000, B=1 → DIFF=0x7FFF_FFFF_FFFF_FFFF, OV=1, BO=0.
- Backpressure: out_ready=0 and in_valid=1 held with sequence A=10..15, B=1.
  - Exactly 4 accepted, then in_ready=0.
  - Out_valid=1 with DIFF=9 held stable.
  - Release out_ready: DIFF=9,10,11,12,13,14 on consecutive cycles, with no gaps or duplicates.
- Random streaming plus reset:
  - 1000 random $random-pair ops with random out_ready/in_valid toggling, checked against the scoreboard model {~BO, DIFF} = {1'b1, A} - {1'b0, B}.
  - Assert rst_n=0 mid-stream: out_valid=0 immediately, and no stale results after release.

Source files
------------

// File: rtl/pipe_subtractor64.sv
// pipe_subtractor64: pipelined WIDTH-bit subtractor (DIFF = A - B) with
// borrow-out and signed-overflow flags. The operand is split into STAGES
// equal slices; stage k resolves slice k and forwards its borrow to stage
// k+1. Valid/ready handshakes on both sides, and an empty stage always
// accepts new data, so bubbles collapse even while the output is stalled.
module pipe_subtractor64 #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] DIFF,
    output logic             BO,
    output logic             OV
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Per-stage state: valid bit, operands (upper slices still unprocessed),
    // the partially resolved difference and the borrow out of its slice.
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] bo_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  d_q [STAGES];
    logic              ov_q;

    // Load enables and the values each stage would capture this cycle.
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_bo;
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_d [STAGES];
    logic [SW:0]       sum   [STAGES];
    logic [WIDTH-1:0]  nxt_d [STAGES];
    logic [STAGES-1:0] nxt_bo;
    logic              nxt_ov;

    // Stage k may load unless it and every stage after it are full and the
    // output is stalled. Built as a running AND so there is no loop through ld.
    always_comb begin
        logic stall;
        stall = !out_ready;
        ld    = '0;
        for (int k = LAST; k >= 0; k--) begin
            stall = stall & v_q[k];
            ld[k] = !stall;
        end
    end

    assign in_ready = ld[0];

    // Select each stage's source: the input ports for stage 0, otherwise the
    // previous stage's registers.
    always_comb begin
        src_v[0]  = in_valid;
        src_a[0]  = A;
        src_b[0]  = B;
        src_d[0]  = '0;
        src_bo[0] = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k]  = v_q[k-1];
            src_a[k]  = a_q[k-1];
            src_b[k]  = b_q[k-1];
            src_d[k]  = d_q[k-1];
            src_bo[k] = bo_q[k-1];
        end
    end

    // Resolve slice k as A_k + ~B_k + carry_in, where carry_in = ~borrow_in
    // (so slice 0 adds 1). The borrow out of the slice is the inverted carry.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            sum[k]   = {1'b0, src_a[k][k*SW +: SW]}
                     + {1'b0, ~src_b[k][k*SW +: SW]}
                     + {{SW{1'b0}}, ~src_bo[k]};
            nxt_d[k] = src_d[k];
            nxt_d[k][k*SW +: SW] = sum[k][SW-1:0];
            nxt_bo[k] = ~sum[k][SW];
        end
        nxt_ov = (src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1])
               & (src_a[LAST][WIDTH-1] ^ nxt_d[LAST][WIDTH-1]);
    end

    // Pipeline registers: a stage takes its source when enabled; the data
    // fields only move when the source is valid, so idle or X inputs never
    // disturb held results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are reset too, not just the valid
            // bits, because DIFF/BO/OV are driven straight from the last
            // stage and must read 0 out of reset.
            v_q  <= '0;
            bo_q <= '0;
            ov_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                d_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    v_q[k] <= src_v[k];
                    if (src_v[k]) begin
                        a_q[k]  <= src_a[k];
                        b_q[k]  <= src_b[k];
                        d_q[k]  <= nxt_d[k];
                        bo_q[k] <= nxt_bo[k];
                    end
                end
            end
            if (ld[LAST] && src_v[LAST]) begin
                ov_q <= nxt_ov;
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign DIFF      = d_q[LAST];
    assign BO        = bo_q[LAST];
    assign OV        = ov_q;

endmodule
